// File: rtl/frame_buffer_manager_pkg.sv
// Shared types for the frame buffer manager: buffer index type and build-time defaults.
// Display geometry and colour depth macros may be predefined by the including build.
`ifndef COLOR_BITS
`define COLOR_BITS 12
`endif
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 16
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 4
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 6
`endif
`define FB_IDX_BITS 2

package frame_buffer_manager_pkg;

    localparam int FB_IDX_BITS = `FB_IDX_BITS;

    typedef logic [FB_IDX_BITS-1:0] fb_idx_t;

    // With three buffers numbered 0..2 the remaining one is 3 - a - b.
    function automatic fb_idx_t fb_third_idx(input fb_idx_t a, input fb_idx_t b);
        return fb_idx_t'(2'd3 - a - b);
    endfunction

endpackage

// File: rtl/fb_role_tracker.sv
// Tracks which buffer is being written, which holds a finished frame, and which is displayed.
// Optional FB_STATS_EN adds saturating dropped/repeated frame counters.
module fb_role_tracker
    import frame_buffer_manager_pkg::*;
#(
    parameter int NUM_BUFFERS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic        frame_start,
    output fb_idx_t     write_idx,
    output fb_idx_t     disp_idx,
    output logic        write_ready
`ifdef FB_STATS_EN
    ,
    output logic [15:0] dropped_frames,
    output logic [15:0] repeated_frames
`endif
);

    fb_idx_t write_idx_q, write_idx_d;
    fb_idx_t disp_idx_q, disp_idx_d;
    fb_idx_t pend_idx_q, pend_idx_d;
    logic    pend_valid_q, pend_valid_d;
    logic    write_ready_q, write_ready_d;
    logic    frame_done_ok;
`ifdef FB_STATS_EN
    logic [15:0] dropped_q, dropped_d;
    logic [15:0] repeated_q, repeated_d;
`endif

    // The vsync handoff is evaluated first so that a same-cycle frame_done
    // installs its frame on top of the already-consumed pending state.
    always_comb begin
        write_idx_d   = write_idx_q;
        disp_idx_d    = disp_idx_q;
        pend_idx_d    = pend_idx_q;
        pend_valid_d  = pend_valid_q;
        write_ready_d = write_ready_q;
        frame_done_ok = frame_done && write_ready_q;
`ifdef FB_STATS_EN
        dropped_d  = dropped_q;
        repeated_d = repeated_q;
        if (frame_start && !pend_valid_q && repeated_q != 16'hFFFF) begin
            repeated_d = repeated_q + 16'd1;
        end
        if (frame_done_ok && pend_valid_q && !frame_start && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end
`endif
        if (frame_start && pend_valid_q) begin
            disp_idx_d   = pend_idx_q;
            pend_valid_d = 1'b0;
            if (NUM_BUFFERS == 2) begin
                write_idx_d   = disp_idx_q;
                write_ready_d = 1'b1;
            end
        end
        if (frame_done_ok) begin
            pend_idx_d   = write_idx_d;
            pend_valid_d = 1'b1;
            if (NUM_BUFFERS == 2) begin
                write_ready_d = 1'b0;
            end else begin
                write_idx_d = fb_third_idx(disp_idx_d, write_idx_d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_idx_q   <= '0;
            disp_idx_q    <= fb_idx_t'(NUM_BUFFERS - 1);
            pend_idx_q    <= '0;
            pend_valid_q  <= 1'b0;
            write_ready_q <= 1'b1;
`ifdef FB_STATS_EN
            dropped_q     <= '0;
            repeated_q    <= '0;
`endif
        end else begin
            write_idx_q   <= write_idx_d;
            disp_idx_q    <= disp_idx_d;
            pend_idx_q    <= pend_idx_d;
            pend_valid_q  <= pend_valid_d;
            write_ready_q <= write_ready_d;
`ifdef FB_STATS_EN
            dropped_q     <= dropped_d;
            repeated_q    <= repeated_d;
`endif
        end
    end

    assign write_idx   = write_idx_q;
    assign disp_idx    = disp_idx_q;
    assign write_ready = write_ready_q;
`ifdef FB_STATS_EN
    assign dropped_frames  = dropped_q;
    assign repeated_frames = repeated_q;
`endif

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM, read-first, with a registered output on port B
// (two-cycle read latency). Port A is used as the write port only.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH = 12,
    parameter int RAM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic                 web,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_b_q;
    logic [RAM_WIDTH-1:0] dout_b_q;

    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem_q[addra] <= dina;
        end
        if (enb) begin
            if (web) begin
                mem_q[addrb] <= dinb;
            end
            ram_b_q <= mem_q[addrb];
        end
        if (regceb) begin
            dout_b_q <= ram_b_q;
        end
    end

    assign doutb = dout_b_q;

endmodule

// File: rtl/frame_buffer_manager.sv
// Tear-free 2/3-buffer frame store between the pixel writer and display scan-out.
// Define FB_STATS_EN to expose dropped_frames / repeated_frames counters.
module frame_buffer_manager
    import frame_buffer_manager_pkg::*;
#(
    parameter int WIDTH       = `COLOR_BITS,
    parameter int DEPTH       = `DISPLAY_WIDTH * `DISPLAY_HEIGHT,
    parameter int ADDR_LEN    = `ADDR_BITS,
    parameter int NUM_BUFFERS = 3,
    localparam int IDX_W      = ($clog2(NUM_BUFFERS) > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_done,
    input  logic                frame_start,
    input  logic                write_enable,
    input  logic [ADDR_LEN-1:0] write_addr,
    input  logic [WIDTH-1:0]    write_data,
    input  logic [ADDR_LEN-1:0] read_addr,
    output logic                write_ready,
    output logic [WIDTH-1:0]    read_data_out,
    output logic [IDX_W-1:0]    display_idx_out,
    output logic [IDX_W-1:0]    write_idx_out
`ifdef FB_STATS_EN
    ,
    output logic [15:0]         dropped_frames,
    output logic [15:0]         repeated_frames
`endif
);

    if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_num_buffers
        $error("frame_buffer_manager: NUM_BUFFERS must be 2 or 3");
    end

    fb_idx_t          write_idx;
    fb_idx_t          disp_idx;
    fb_idx_t          sel1_q, sel1_d, sel2_q, sel2_d;
    logic             vld1_q, vld1_d, vld2_q, vld2_d;
    logic [WIDTH-1:0] ram_dout [NUM_BUFFERS];
    logic [WIDTH-1:0] rd_mux;

    fb_role_tracker #(
        .NUM_BUFFERS (NUM_BUFFERS)
    ) u_roles (
        .clk             (clk),
        .rst             (rst),
        .frame_done      (frame_done),
        .frame_start     (frame_start),
        .write_idx       (write_idx),
        .disp_idx        (disp_idx),
        .write_ready     (write_ready)
`ifdef FB_STATS_EN
        ,
        .dropped_frames  (dropped_frames),
        .repeated_frames (repeated_frames)
`endif
    );

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
        xilinx_true_dual_port_read_first_1_clock_ram #(
            .RAM_WIDTH (WIDTH),
            .RAM_DEPTH (DEPTH),
            .ADDR_W    (ADDR_LEN)
        ) u_ram (
            .clk    (clk),
            .ena    (1'b1),
            .wea    (write_enable && write_ready && !rst && (write_idx == fb_idx_t'(g))),
            .addra  (write_addr),
            .dina   (write_data),
            .enb    (1'b1),
            .web    (1'b0),
            .addrb  (read_addr),
            .dinb   ('0),
            .regceb (1'b1),
            .doutb  (ram_dout[g])
        );
    end

    // The display index follows the RAM's two read stages so the selected buffer
    // always matches the data emerging; vld gates out stale RAM registers after reset.
    always_comb begin
        sel1_d = disp_idx;
        sel2_d = sel1_q;
        vld1_d = 1'b1;
        vld2_d = vld1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1_q <= fb_idx_t'(NUM_BUFFERS - 1);
            sel2_q <= fb_idx_t'(NUM_BUFFERS - 1);
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (sel2_q == fb_idx_t'(b)) begin
                rd_mux = ram_dout[b];
            end
        end
    end

    assign read_data_out   = vld2_q ? rd_mux : '0;
    assign display_idx_out = IDX_W'(sel2_q);
    assign write_idx_out   = IDX_W'(write_idx);

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Drives a triple- and a double-buffered instance with one shared stimulus stream and
// compares both against a frame-role reference model and a read-data scoreboard.
module tb_frame_buffer_manager;

    localparam int W  = 12;
    localparam int D  = 64;
    localparam int A  = 6;
    localparam int EW = W + 3;

    logic         clk;
    logic         rst;
    logic         frame_done;
    logic         frame_start;
    logic         write_enable;
    logic [A-1:0] write_addr;
    logic [W-1:0] write_data;
    logic [A-1:0] read_addr;

    logic         wrdy3, wrdy2;
    logic [W-1:0] rdata3, rdata2;
    logic [1:0]   didx3, widx3;
    logic [0:0]   didx2, widx2;
`ifdef FB_STATS_EN
    logic [15:0]  drop3, rep3, drop2, rep2;
    int           m_drop[2];
    int           m_rep[2];
`endif

    int n_cmp;
    int n_err;

    // Reference model: index 0 is the 3-buffer instance, index 1 the 2-buffer one.
    int           m_w[2];
    int           m_d[2];
    int           m_p[2];
    bit           m_pv[2];
    bit           m_rdy[2];
    logic [W-1:0] mem[2][3][D];
    bit           known[2][3][D];
    logic [EW-1:0] exp3_q[$];
    logic [EW-1:0] exp2_q[$];

    frame_buffer_manager #(
        .WIDTH (W), .DEPTH (D), .ADDR_LEN (A), .NUM_BUFFERS (3)
    ) u_dut3 (
        .clk             (clk),
        .rst             (rst),
        .frame_done      (frame_done),
        .frame_start     (frame_start),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .read_addr       (read_addr),
        .write_ready     (wrdy3),
        .read_data_out   (rdata3),
        .display_idx_out (didx3),
        .write_idx_out   (widx3)
`ifdef FB_STATS_EN
        ,
        .dropped_frames  (drop3),
        .repeated_frames (rep3)
`endif
    );

    frame_buffer_manager #(
        .WIDTH (W), .DEPTH (D), .ADDR_LEN (A), .NUM_BUFFERS (2)
    ) u_dut2 (
        .clk             (clk),
        .rst             (rst),
        .frame_done      (frame_done),
        .frame_start     (frame_start),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .read_addr       (read_addr),
        .write_ready     (wrdy2),
        .read_data_out   (rdata2),
        .display_idx_out (didx2),
        .write_idx_out   (widx2)
`ifdef FB_STATS_EN
        ,
        .dropped_frames  (drop2),
        .repeated_frames (rep2)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_w[i]   = 0;
            m_d[i]   = (i == 0) ? 2 : 1;
            m_p[i]   = 0;
            m_pv[i]  = 1'b0;
            m_rdy[i] = 1'b1;
`ifdef FB_STATS_EN
            m_drop[i] = 0;
            m_rep[i]  = 0;
`endif
        end
        exp3_q.delete();
        exp2_q.delete();
    endtask

    // One clock of frame-role rules, evaluated on the pre-edge state and inputs.
    task automatic model_step(input int i);
        int            n;
        int            old_d;
        bit            fd_ok;
        logic [EW-1:0] e;
        n = (i == 0) ? 3 : 2;
        e = {known[i][m_d[i]][read_addr], 2'(m_d[i]), mem[i][m_d[i]][read_addr]};
        if (i == 0) exp3_q.push_back(e);
        else        exp2_q.push_back(e);
        if (write_enable && m_rdy[i]) begin
            mem[i][m_w[i]][write_addr]   = write_data;
            known[i][m_w[i]][write_addr] = 1'b1;
        end
        fd_ok = frame_done && m_rdy[i];
        if (frame_start) begin
            if (m_pv[i]) begin
                old_d   = m_d[i];
                m_d[i]  = m_p[i];
                m_pv[i] = 1'b0;
                if (n == 2) begin
                    m_w[i]   = old_d;
                    m_rdy[i] = 1'b1;
                end
            end else begin
`ifdef FB_STATS_EN
                if (m_rep[i] < 65535) m_rep[i]++;
`endif
            end
        end
        if (fd_ok) begin
`ifdef FB_STATS_EN
            if (m_pv[i] && m_drop[i] < 65535) m_drop[i]++;
`endif
            m_p[i]  = m_w[i];
            m_pv[i] = 1'b1;
            if (n == 2) begin
                m_rdy[i] = 1'b0;
            end else begin
                for (int b = 0; b < 3; b++) begin
                    if (b != m_d[i] && b != m_p[i]) m_w[i] = b;
                end
            end
        end
    endtask

    task automatic score(input int i, input logic [W-1:0] rd, input logic [31:0] didx);
        logic [EW-1:0] e;
        bit            have;
        int            n;
        n    = (i == 0) ? 3 : 2;
        have = 1'b0;
        e    = '0;
        if (i == 0 && exp3_q.size() == 2) begin e = exp3_q.pop_front(); have = 1'b1; end
        if (i == 1 && exp2_q.size() == 2) begin e = exp2_q.pop_front(); have = 1'b1; end
        if (have) begin
            check($sformatf("disp_idx_n%0d", n), didx, 32'(e[W+1:W]));
            if (e[EW-1]) check($sformatf("read_data_n%0d", n), 32'(rd), 32'(e[W-1:0]));
        end else begin
            check($sformatf("disp_idx_warm_n%0d", n), didx, 32'(n - 1));
            check($sformatf("read_data_warm_n%0d", n), 32'(rd), 32'd0);
        end
    endtask

    task automatic check_outputs();
        check("write_idx_n3", 32'(widx3), 32'(m_w[0]));
        check("write_ready_n3", 32'(wrdy3), 32'(m_rdy[0]));
        check("write_idx_n2", 32'(widx2), 32'(m_w[1]));
        check("write_ready_n2", 32'(wrdy2), 32'(m_rdy[1]));
        score(0, rdata3, 32'(didx3));
        score(1, rdata2, 32'(didx2));
`ifdef FB_STATS_EN
        check("dropped_n3", 32'(drop3), 32'(m_drop[0]));
        check("repeated_n3", 32'(rep3), 32'(m_rep[0]));
        check("dropped_n2", 32'(drop2), 32'(m_drop[1]));
        check("repeated_n2", 32'(rep2), 32'(m_rep[1]));
`endif
    endtask

    task automatic check_reset_values();
        check("rst_write_idx_n3", 32'(widx3), 32'd0);
        check("rst_disp_idx_n3", 32'(didx3), 32'd2);
        check("rst_ready_n3", 32'(wrdy3), 32'd1);
        check("rst_data_n3", 32'(rdata3), 32'd0);
        check("rst_write_idx_n2", 32'(widx2), 32'd0);
        check("rst_disp_idx_n2", 32'(didx2), 32'd1);
        check("rst_ready_n2", 32'(wrdy2), 32'd1);
        check("rst_data_n2", 32'(rdata2), 32'd0);
`ifdef FB_STATS_EN
        check("rst_dropped_n3", 32'(drop3), 32'd0);
        check("rst_repeated_n3", 32'(rep3), 32'd0);
`endif
    endtask

    // driver tasks
    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit fd, input bit fs, input bit we, input int wa, input int wd,
                         input int ra);
        frame_done   = fd;
        frame_start  = fs;
        write_enable = we;
        write_addr   = A'(wa);
        write_data   = W'(wd);
        read_addr    = A'(ra);
        cycle();
    endtask

    task automatic idle(input int cycles, input int ra);
        for (int k = 0; k < cycles; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, ra);
    endtask

    task automatic random_phase(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            frame_done   = ($urandom_range(0, 9) == 0);
            frame_start  = ($urandom_range(0, 11) == 0);
            write_enable = ($urandom_range(0, 1) == 1);
            write_addr   = ($urandom_range(0, 3) == 0) ? A'($urandom_range(0, D - 1))
                                                       : A'($urandom_range(0, 7));
            write_data   = W'($urandom);
            read_addr    = ($urandom_range(0, 3) == 0) ? A'($urandom_range(0, D - 1))
                                                       : A'($urandom_range(0, 7));
            cycle();
        end
    endtask

    // Called just after a checked edge: reset lands between clock edges.
    task automatic mid_frame_reset();
        #3;
        rst          = 1'b1;
        frame_done   = 1'b0;
        frame_start  = 1'b0;
        write_enable = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        frame_done   = 1'b0;
        frame_start  = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_addr    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // write, finish, hand off, read back
        drive(1'b0, 1'b0, 1'b1, 5, 'hA, 5);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 5);
        drive(1'b0, 1'b1, 1'b1, 5, 'h3C, 5);
        idle(4, 5);

        // two finished frames before one vsync
        drive(1'b0, 1'b0, 1'b1, 6, 'h111, 6);
        drive(1'b1, 1'b0, 1'b1, 6, 'h222, 6);
        drive(1'b0, 1'b0, 1'b1, 6, 'h333, 6);
        drive(1'b1, 1'b0, 1'b1, 6, 'h444, 6);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 6);
        idle(4, 6);

        // frame_done and frame_start together with a frame pending
        drive(1'b1, 1'b0, 1'b1, 7, 'h555, 7);
        drive(1'b1, 1'b1, 1'b1, 7, 'h666, 7);
        idle(3, 7);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 7);
        idle(3, 7);

        // vsync with nothing pending, three times
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 0, 0, 5);
            idle(2, 5);
        end

        random_phase(3000);
        mid_frame_reset();
        drive(1'b1, 1'b0, 1'b0, 0, 0, 5);
        drive(1'b0, 1'b1, 1'b0, 0, 0, 5);
        idle(4, 5);
        random_phase(1500);

        frame_done   = 1'b0;
        frame_start  = 1'b0;
        write_enable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
